// File: rtl/dma_pkg.sv
// Shared DMA definitions: request FSM states, handshake active levels and
// the 8-bit byte-count type used by both the device port and the controller.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } dma_state_e;

  localparam logic DREQ_ACTIVE = 1'b1;
  localparam logic DACK_ACTIVE = 1'b1;

  typedef logic [7:0] byte_cnt_t;

endpackage

// File: rtl/dma_byte_fifo.sv
// Synchronous byte FIFO with wrapping pointers and a separate occupancy
// counter; exposes the head word combinationally.
module dma_byte_fifo
  import dma_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DW-1:0]              din_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dma_dev_port.sv
// Peripheral-side DREQ/DACK endpoint: buffers device bytes and delivers them on DB.
// Define DMA_DEMAND_MODE_EN for demand-mode bursts; otherwise one byte per request.
module dma_dev_port
  import dma_pkg::*;
#(
  parameter int DW        = 8,
  parameter int DEPTH     = 8,
  parameter int THRESH    = 4,
  parameter int BLOCK_LEN = 30
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DW-1:0]          DIN,
  input  logic                   DIN_VALID,
  output logic                   DIN_READY,
  input  logic                   FLUSH,
  output logic                   DREQ,
  input  logic                   DACK,
  inout  wire  [DW-1:0]          DB,
  output logic                   DONE,
  output logic                   UNDERRUN,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int              CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   THRESH_C = CW'(THRESH);
  localparam byte_cnt_t       BLOCK_C  = byte_cnt_t'(BLOCK_LEN);
`ifdef DMA_DEMAND_MODE_EN
  localparam bit              DEMAND   = 1'b1;
`else
  localparam bit              DEMAND   = 1'b0;
`endif

  logic [DW-1:0] head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          ack, push, xfer;
  logic          block_end, drains;
  byte_cnt_t     byte_cnt_q, byte_cnt_inc;
  dma_state_e    state_q;
  logic          dreq_q, done_q, underrun_q;

  assign ack          = (DACK == DACK_ACTIVE);
  assign push         = DIN_VALID && !full;
  assign xfer         = ack && !empty;
  assign byte_cnt_inc = byte_cnt_q + 8'd1;
  assign block_end    = xfer && (byte_cnt_inc == BLOCK_C);
  // the pop empties the FIFO only if no push lands on the same edge
  assign drains       = xfer && (count == CW'(1)) && !push;

  dma_byte_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .din_i   (DIN),
    .pop_i   (xfer),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign DB        = ack ? (empty ? {DW{1'b0}} : head) : {DW{1'bz}};
  assign DIN_READY = !full;
  assign COUNT     = count;
  assign DREQ      = dreq_q;
  assign DONE      = done_q;
  assign UNDERRUN  = underrun_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      dreq_q     <= ~DREQ_ACTIVE;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      done_q <= block_end;
      if (ack && empty) underrun_q <= 1'b1;
      if (xfer) byte_cnt_q <= block_end ? '0 : byte_cnt_inc;

      case (state_q)
        ST_IDLE: begin
          if ((count >= THRESH_C) || (FLUSH && !empty)) begin
            state_q <= ST_REQ;
            dreq_q  <= DREQ_ACTIVE;
          end
        end
        ST_REQ: begin
          if (xfer && (block_end || drains || !DEMAND)) begin
            state_q <= ST_GAP;
            dreq_q  <= ~DREQ_ACTIVE;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
          dreq_q  <= ~DREQ_ACTIVE;
        end
        default: begin
          state_q <= ST_IDLE;
          dreq_q  <= ~DREQ_ACTIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_dev_port.sv
// Self-checking bench for dma_dev_port: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dma_dev_port;

  localparam int DW        = 8;
  localparam int DEPTH     = 8;
  localparam int THRESH    = 4;
  localparam int BLOCK_LEN = 30;
`ifdef DMA_DEMAND_MODE_EN
  localparam bit DEMAND = 1'b1;
`else
  localparam bit DEMAND = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] DIN;
  logic          DIN_VALID;
  logic          DIN_READY;
  logic          FLUSH;
  logic          DREQ;
  logic          DACK;
  wire  [DW-1:0] DB;
  logic          DONE;
  logic          UNDERRUN;
  logic [3:0]    COUNT;

  dma_dev_port #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .THRESH    (THRESH),
    .BLOCK_LEN (BLOCK_LEN)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .FLUSH     (FLUSH),
    .DREQ      (DREQ),
    .DACK      (DACK),
    .DB        (DB),
    .DONE      (DONE),
    .UNDERRUN  (UNDERRUN),
    .COUNT     (COUNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus request/gap flags driven by the rules.
  logic [7:0] m_q[$];
  int         m_bcnt;
  bit         m_req, m_gap, m_done, m_und;

  task automatic model_step();
    int n;
    bit pop, push, leave;
    if (RST) begin
      m_q.delete();
      m_bcnt = 0; m_req = 0; m_gap = 0; m_done = 0; m_und = 0;
      return;
    end
    n     = m_q.size();
    pop   = DACK && (n > 0);
    push  = DIN_VALID && (n < DEPTH);
    leave = 0;
    m_done = 0;
    if (DACK && n == 0) m_und = 1;
    if (pop) begin
      void'(m_q.pop_front());
      m_bcnt++;
      if (m_bcnt == BLOCK_LEN) begin
        m_bcnt = 0;
        m_done = 1;
        leave  = 1;
      end
    end
    if (push) m_q.push_back(DIN);
    if (pop && m_q.size() == 0) leave = 1;
    if (m_gap) m_gap = 0;
    else if (m_req) begin
      if (pop && (leave || !DEMAND)) begin
        m_req = 0;
        m_gap = 1;
      end
    end else if (n >= THRESH || (FLUSH && n > 0)) m_req = 1;
  endtask

  initial begin
    @(posedge CLK);
    model_step();
    forever begin
      @(negedge CLK);
      #2;
      chk("DREQ", int'(DREQ), int'(m_req));
      chk("DONE", int'(DONE), int'(m_done));
      chk("UNDERRUN", int'(UNDERRUN), int'(m_und));
      chk("COUNT", int'(COUNT), m_q.size());
      chk("DIN_READY", int'(DIN_READY), int'(m_q.size() < DEPTH));
      if (DACK) chk("DB", int'(DB), (m_q.size() > 0) ? int'(m_q[0]) : 0);
      @(posedge CLK);
      model_step();
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_dreq();
    for (int k = 0; k < 20; k++) begin
      if (DREQ) return;
      tick();
    end
    chk("dreq_timeout", 0, 1);
  endtask

  initial begin
    int xfers, dones;
    logic [7:0] b;
    RST = 1'b1; DIN = '0; DIN_VALID = 1'b0; FLUSH = 1'b0; DACK = 1'b0;
    @(negedge CLK);
    tick();
    RST = 1'b0;
    tick();
    chk("rst_dreq", int'(DREQ), 0);
    chk("rst_count", int'(COUNT), 0);
    chk("rst_ready", int'(DIN_READY), 1);
    chk("rst_underrun", int'(UNDERRUN), 0);

    // Four bytes reach the threshold; DREQ follows one edge later.
    for (int i = 0; i < 4; i++) begin
      DIN = 8'(8'hA0 + i);
      DIN_VALID = 1'b1;
      tick();
    end
    DIN_VALID = 1'b0;
    chk("thresh_count", int'(COUNT), 4);
    chk("thresh_dreq_before", int'(DREQ), 0);
    tick();
    chk("thresh_dreq_after", int'(DREQ), 1);

    // Service: continuous DACK in demand mode, one pulse per request otherwise.
    FLUSH = !DEMAND;
    for (int i = 0; i < 4; i++) begin
      wait_dreq();
      DACK = 1'b1;
      #1;
      chk("svc_db", int'(DB), 8'hA0 + i);
      tick();
      if (!DEMAND) begin
        DACK = 1'b0;
        chk("single_drop", int'(DREQ), 0);
      end
    end
    DACK = 1'b0; FLUSH = 1'b0;
    chk("svc_dreq_low", int'(DREQ), 0);
    chk("svc_count", int'(COUNT), 0);

    // Underrun: DACK with an empty FIFO.
    tick();
    DACK = 1'b1;
    #1;
    chk("underrun_db", int'(DB), 0);
    tick();
    DACK = 1'b0;
    chk("underrun_flag", int'(UNDERRUN), 1);
    chk("underrun_count", int'(COUNT), 0);
    tick(); tick();
    chk("underrun_sticky", int'(UNDERRUN), 1);

    // Flush of a sub-threshold residue.
    for (int i = 0; i < 2; i++) begin
      DIN = 8'(8'hB0 + i);
      DIN_VALID = 1'b1;
      tick();
    end
    DIN_VALID = 1'b0;
    FLUSH = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_dreq();
      DACK = 1'b1;
      #1;
      chk("flush_db", int'(DB), 8'hB0 + i);
      tick();
      DACK = 1'b0;
    end
    FLUSH = 1'b0;
    tick();
    chk("flush_dreq_low", int'(DREQ), 0);
    chk("flush_count", int'(COUNT), 0);

    // Overfill: the ninth byte is refused.
    DIN_VALID = 1'b1;
    for (int i = 0; i < 9; i++) begin
      DIN = 8'(8'hC0 + i);
      tick();
    end
    DIN_VALID = 1'b0;
    chk("full_count", int'(COUNT), 8);
    chk("full_ready", int'(DIN_READY), 0);
    DACK = 1'b1;
    #1;
    chk("full_head", int'(DB), 8'hC0);
    tick();
    DIN = 8'hD0; DIN_VALID = 1'b1;
    #1;
    chk("pushpop_head", int'(DB), 8'hC1);
    tick();
    DIN_VALID = 1'b0;
    chk("pushpop_count", int'(COUNT), 7);
    for (int j = 0; j < 7; j++) begin
      #1;
      chk("drain_db", int'(DB), (j < 6) ? 8'hC2 + j : 8'hD0);
      tick();
    end
    DACK = 1'b0;
    chk("drain_count", int'(COUNT), 0);

    // Reset in the middle of a burst.
    DIN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      DIN = 8'(8'hE0 + i);
      tick();
    end
    DIN_VALID = 1'b0;
    wait_dreq();
    DACK = 1'b1;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0; DACK = 1'b0;
    chk("midrst_dreq", int'(DREQ), 0);
    chk("midrst_count", int'(COUNT), 0);
    chk("midrst_underrun", int'(UNDERRUN), 0);
    chk("midrst_done", int'(DONE), 0);

    // One full block: DONE pulses once, right after the 30th transfer.
    xfers = 0; dones = 0;
    FLUSH = 1'b1; DIN_VALID = 1'b1;
    for (int c = 0; c < 400; c++) begin
      DIN  = 8'($urandom);
      DACK = DREQ;
      #1;
      if (DACK && COUNT != 0) xfers++;
      tick();
      if (DONE) dones++;
      if (xfers == BLOCK_LEN) break;
    end
    chk("block_xfers", xfers, BLOCK_LEN);
    chk("block_done_pulse", int'(DONE), 1);
    chk("block_done_once", dones, 1);
    chk("block_dreq_drop", int'(DREQ), 0);
    chk("block_fifo_nonempty", int'(COUNT != 0), 1);
    DACK = 1'b0; DIN_VALID = 1'b0; FLUSH = 1'b0;
    tick();
    chk("block_done_clear", int'(DONE), 0);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      RST       = ($urandom_range(0, 199) == 0);
      b         = 8'($urandom);
      DIN       = b;
      DIN_VALID = ($urandom_range(0, 9) < 6);
      FLUSH     = ($urandom_range(0, 9) == 0);
      DACK      = DREQ ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) == 0);
      tick();
    end
    RST = 1'b0; DACK = 1'b0; DIN_VALID = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
